// File: rtl/fft_radix2_iterative.sv
// Iterative in-place radix-2 DIT FFT for real samples: bit-reversed load, one
// butterfly per clock with 1/2 scaling per stage (net DFT/N), natural-order unload.
module fft_radix2_iterative #(
    parameter int POINTS           = 8,
    parameter int SAMPLE_SIZE      = 16,
    parameter int CALCULATION_SIZE = 24,
    parameter int TWIDDLE_SIZE     = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [SAMPLE_SIZE-1:0]      in_real,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [CALCULATION_SIZE-1:0] out_real,
    output logic signed [CALCULATION_SIZE-1:0] out_imag,
    output logic [$clog2(POINTS)-1:0]          out_index,
    output logic                               out_last,
    output logic                               busy
);
    localparam int LOG2 = $clog2(POINTS);
    localparam int CW   = CALCULATION_SIZE;
    localparam int TW   = TWIDDLE_SIZE;
    localparam int PW   = CW + TW + 1;
    localparam logic [LOG2-1:0] LAST_IDX   = LOG2'(POINTS - 1);
    localparam logic [LOG2-1:0] LAST_STAGE = LOG2'(LOG2 - 1);
    localparam logic [LOG2-2:0] LAST_BFLY  = (LOG2-1)'(POINTS / 2 - 1);
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = real'(1 << (TW - 2));

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t                r_state, w_next_state;
    logic [LOG2-1:0]       r_load_cnt;
    logic [LOG2-1:0]       r_stage;
    logic [LOG2-2:0]       r_bfly;
    logic                  r_out_valid, r_out_last;
    logic [LOG2-1:0]       r_out_index;
    logic signed [CW-1:0]  r_out_real, r_out_imag;
    logic signed [CW-1:0]  r_mem_re [POINTS];
    logic signed [CW-1:0]  r_mem_im [POINTS];

    logic signed [TW-1:0]  w_tw_re [POINTS/2];
    logic signed [TW-1:0]  w_tw_im [POINTS/2];

    // W(idx) = exp(-j*2*pi*idx/N), rounded to nearest at elaboration.
    for (genvar i = 0; i < POINTS / 2; i++) begin : g_twiddle
        localparam real ANG  = 2.0 * PI * real'(i) / real'(POINTS);
        localparam int  C_RE = $rtoi($floor(SCALE * $cos(ANG) + 0.5));
        localparam int  C_IM = $rtoi($floor(-SCALE * $sin(ANG) + 0.5));
        assign w_tw_re[i] = TW'(C_RE);
        assign w_tw_im[i] = TW'(C_IM);
    end

    logic [LOG2-1:0] w_load_addr;
    for (genvar i = 0; i < LOG2; i++) begin : g_bitrev
        assign w_load_addr[i] = r_load_cnt[LOG2-1-i];
    end

    logic            w_in_fire, w_out_fire, w_last_bfly;
    logic [LOG2-1:0] w_j, w_h, w_p, w_a_addr, w_b_addr, w_rd_idx;
    logic [LOG2-2:0] w_tw_idx;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_last_bfly = (r_stage == LAST_STAGE) && (r_bfly == LAST_BFLY);

    // Butterfly j of stage s: A = g*2h + p, B = A + h, twiddle index p*N/(2h).
    assign w_j      = {1'b0, r_bfly};
    assign w_h      = LOG2'(1) << r_stage;
    assign w_p      = w_j & (w_h - 1'b1);
    assign w_a_addr = ((w_j >> r_stage) << (r_stage + 1'b1)) | w_p;
    assign w_b_addr = w_a_addr | w_h;
    assign w_tw_idx = (LOG2-1)'(w_p << (LAST_STAGE - r_stage));
    assign w_rd_idx = r_out_valid ? r_out_index + 1'b1 : r_out_index;

    logic signed [CW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [TW-1:0] w_w_re, w_w_im;
    logic signed [PW-1:0] w_prod_re, w_prod_im, w_t_re, w_t_im;
    logic signed [PW-1:0] w_sa_re, w_sa_im, w_sb_re, w_sb_im;
    logic signed [CW-1:0] w_na_re, w_na_im, w_nb_re, w_nb_im;

    assign w_a_re = r_mem_re[w_a_addr];
    assign w_a_im = r_mem_im[w_a_addr];
    assign w_b_re = r_mem_re[w_b_addr];
    assign w_b_im = r_mem_im[w_b_addr];
    assign w_w_re = w_tw_re[w_tw_idx];
    assign w_w_im = w_tw_im[w_tw_idx];

    assign w_prod_re = PW'(w_b_re) * PW'(w_w_re) - PW'(w_b_im) * PW'(w_w_im);
    assign w_prod_im = PW'(w_b_re) * PW'(w_w_im) + PW'(w_b_im) * PW'(w_w_re);
    assign w_t_re    = w_prod_re >>> (TW - 2);
    assign w_t_im    = w_prod_im >>> (TW - 2);

    // The sums keep a guard bit so the halving never loses the carry.
    assign w_sa_re = PW'(w_a_re) + w_t_re;
    assign w_sa_im = PW'(w_a_im) + w_t_im;
    assign w_sb_re = PW'(w_a_re) - w_t_re;
    assign w_sb_im = PW'(w_a_im) - w_t_im;
    assign w_na_re = CW'(w_sa_re >>> 1);
    assign w_na_im = CW'(w_sa_im >>> 1);
    assign w_nb_re = CW'(w_sb_re >>> 1);
    assign w_nb_im = CW'(w_sb_im >>> 1);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_load_cnt == LAST_IDX) w_next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_last_bfly) w_next_state = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy = 1'b1;
                if (w_out_fire && r_out_last) w_next_state = S_LOAD;
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    // NOTE: the buffer has no reset; every word is rewritten by LOAD before it is read.
    always_ff @(posedge clock) begin
        if (r_state == S_LOAD && w_in_fire) begin
            r_mem_re[w_load_addr] <= CW'(in_real);
            r_mem_im[w_load_addr] <= '0;
        end else if (r_state == S_COMPUTE) begin
            r_mem_re[w_a_addr] <= w_na_re;
            r_mem_im[w_a_addr] <= w_na_im;
            r_mem_re[w_b_addr] <= w_nb_re;
            r_mem_im[w_b_addr] <= w_nb_im;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_cnt  <= '0;
            r_stage     <= '0;
            r_bfly      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_index <= '0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            case (r_state)
                S_LOAD: if (w_in_fire) r_load_cnt <= r_load_cnt + 1'b1;
                S_COMPUTE: begin
                    if (r_bfly == LAST_BFLY) begin
                        r_bfly  <= '0;
                        r_stage <= w_last_bfly ? '0 : r_stage + 1'b1;
                    end else begin
                        r_bfly <= r_bfly + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    // First cycle primes bin 0; afterwards a handshake fetches the next bin.
                    if (!r_out_valid || (out_ready && !r_out_last)) begin
                        r_out_valid <= 1'b1;
                        r_out_index <= w_rd_idx;
                        r_out_real  <= r_mem_re[w_rd_idx];
                        r_out_imag  <= r_mem_im[w_rd_idx];
                        r_out_last  <= (w_rd_idx == LAST_IDX);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_index <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_index = r_out_index;
    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;

endmodule

// File: tb/tb_fft_radix2_iterative.sv
// Directed bench for fft_radix2_iterative: impulse, DC, alternating, N=16 cosine,
// output backpressure and mid-frame reset, with hand-computed expected bins.
module tb_fft_radix2_iterative;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic               in_valid_8, in_ready_8, out_valid_8, out_ready_8, out_last_8, busy_8;
    logic signed [15:0] in_real_8;
    logic signed [23:0] out_real_8, out_imag_8;
    logic [2:0]         out_index_8;

    logic               in_valid_16, in_ready_16, out_valid_16, out_ready_16, out_last_16, busy_16;
    logic signed [15:0] in_real_16;
    logic signed [23:0] out_real_16, out_imag_16;
    logic [3:0]         out_index_16;

    fft_radix2_iterative #(.POINTS(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_real(in_real_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_real(out_real_8), .out_imag(out_imag_8), .out_index(out_index_8),
        .out_last(out_last_8), .busy(busy_8)
    );

    fft_radix2_iterative #(.POINTS(16)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_16), .in_ready(in_ready_16), .in_real(in_real_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .out_real(out_real_16), .out_imag(out_imag_16), .out_index(out_index_16),
        .out_last(out_last_16), .busy(busy_16)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic signed [15:0] x8 [8];
    int                 e_re [8];
    int                 e_im [8];
    logic signed [15:0] cos_tab [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [31:0] obs, input int exp, input int tol);
        n_asserts++;
        assert (!$isunknown(obs) && obs >= exp - tol && obs <= exp + tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic send8();
        for (int n = 0; n < 8; n++) begin
            in_valid_8 = 1'b1;
            in_real_8  = x8[n];
            @(posedge clock); #1;
        end
        in_valid_8 = 1'b0;
        in_real_8  = '0;
    endtask

    task automatic wait_valid8(output int cycles);
        cycles = 0;
        while (!out_valid_8 && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
        end
        if (!out_valid_8) check("wait_out_valid_8", out_valid_8, 1);
    endtask

    task automatic recv8(input string name, input int tol);
        int cyc;
        out_ready_8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_valid8(cyc);
            check($sformatf("%s idx%0d", name, k), out_index_8, k);
            check($sformatf("%s last%0d", name, k), out_last_8, (k == 7) ? 1 : 0);
            check_tol($sformatf("%s re%0d", name, k), out_real_8, e_re[k], tol);
            check_tol($sformatf("%s im%0d", name, k), out_imag_8, e_im[k], tol);
            @(posedge clock); #1;
        end
        check({name, " done_out_valid"}, out_valid_8, 0);
        check({name, " done_in_ready"}, in_ready_8, 1);
        check({name, " done_busy"}, busy_8, 0);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < 8; n++) begin
            x8[n]   = (n == 0) ? 16'sd1000 : 16'sd0;
            e_re[n] = 125;
            e_im[n] = 0;
        end
    endtask

    initial begin
        int cyc, got, hold;
        logic prev_stall;
        logic signed [31:0] p_re, p_im;
        logic [2:0] p_idx;
        logic p_last;

        reset = 1'b1;
        in_valid_8 = 1'b0; in_real_8 = '0; out_ready_8 = 1'b1;
        in_valid_16 = 1'b0; in_real_16 = '0; out_ready_16 = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst in_ready", in_ready_8, 1);
        check("rst out_valid", out_valid_8, 0);
        check("rst busy", busy_8, 0);
        check("rst out_last", out_last_8, 0);
        check("rst out_index", out_index_8, 0);
        check("rst out_real", out_real_8, 0);
        check("rst out_imag", out_imag_8, 0);

        // Impulse: flat spectrum of 1000/8 and 13-cycle latency.
        set_impulse();
        send8();
        check("imp in_ready_after_last", in_ready_8, 0);
        check("imp busy_compute", busy_8, 1);
        wait_valid8(cyc);
        check("imp latency", cyc, 13);
        recv8("imp", 0);

        // DC 800: everything lands in bin 0.
        for (int n = 0; n < 8; n++) begin
            x8[n]   = 16'sd800;
            e_re[n] = (n == 0) ? 800 : 0;
            e_im[n] = 0;
        end
        send8();
        recv8("dc", 0);

        // Alternating +/-1000: everything lands in bin 4 (Nyquist).
        for (int n = 0; n < 8; n++) begin
            x8[n]   = (n % 2 == 0) ? 16'sd1000 : -16'sd1000;
            e_re[n] = (n == 4) ? 1000 : 0;
            e_im[n] = 0;
        end
        send8();
        recv8("alt", 1);

        // N=16 cosine at bin 2: half amplitude in bins 2 and 14.
        for (int n = 0; n < 16; n++) begin
            in_valid_16 = 1'b1;
            in_real_16  = cos_tab[n % 8];
            @(posedge clock); #1;
        end
        in_valid_16 = 1'b0;
        check("cos16 in_ready_after_last", in_ready_16, 0);
        for (int k = 0; k < 16; k++) begin
            cyc = 0;
            while (!out_valid_16 && cyc < 300) begin
                @(posedge clock); #1;
                cyc++;
            end
            if (k == 0) check("cos16 latency", cyc, 33);
            check($sformatf("cos16 idx%0d", k), out_index_16, k);
            check_tol($sformatf("cos16 re%0d", k), out_real_16, (k == 2 || k == 14) ? 8192 : 0, 2);
            check_tol($sformatf("cos16 im%0d", k), out_imag_16, 0, 2);
            @(posedge clock); #1;
        end
        check("cos16 done_out_valid", out_valid_16, 0);

        // Backpressure: toggled ready, 5-cycle stall on bin 3, impulse frame.
        set_impulse();
        send8();
        got = 0; cyc = 0; hold = 0; prev_stall = 1'b0;
        p_re = '0; p_im = '0; p_idx = '0; p_last = 1'b0;
        while (got < 8 && cyc < 300) begin
            if (prev_stall) begin
                check("bp hold_valid", out_valid_8, 1);
                check("bp hold_idx", out_index_8, p_idx);
                check("bp hold_re", out_real_8, p_re);
                check("bp hold_im", out_imag_8, p_im);
                check("bp hold_last", out_last_8, p_last);
            end
            check("bp in_ready_low", in_ready_8, 0);
            if (out_valid_8 && out_index_8 == 3'd3 && hold < 5) begin
                out_ready_8 = 1'b0;
                hold++;
            end else begin
                out_ready_8 = cyc[0];
            end
            prev_stall = out_valid_8 && !out_ready_8;
            p_re = out_real_8; p_im = out_imag_8; p_idx = out_index_8; p_last = out_last_8;
            if (out_valid_8 && out_ready_8) begin
                check($sformatf("bp idx%0d", got), out_index_8, got);
                check($sformatf("bp re%0d", got), out_real_8, 125);
                check($sformatf("bp last%0d", got), out_last_8, (got == 7) ? 1 : 0);
                got++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_ready_8 = 1'b1;
        check("bp bins_delivered", got, 8);
        check("bp stall_cycles", hold, 5);
        check("bp done_out_valid", out_valid_8, 0);
        check("bp done_in_ready", in_ready_8, 1);

        // Reset during COMPUTE.
        send8();
        repeat (4) begin @(posedge clock); #1; end
        check("rc busy_before", busy_8, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rc in_ready", in_ready_8, 1);
        check("rc out_valid", out_valid_8, 0);
        check("rc busy", busy_8, 0);

        // Reset during UNLOAD, after two bins.
        send8();
        wait_valid8(cyc);
        repeat (2) begin @(posedge clock); #1; end
        check("ru idx_before", out_index_8, 2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("ru in_ready", in_ready_8, 1);
        check("ru out_valid", out_valid_8, 0);
        check("ru busy", busy_8, 0);
        check("ru out_index", out_index_8, 0);

        send8();
        recv8("post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
